flash_copy_master: RTL and testbench
====================================

# flash_copy_master

Avalon-MM master that copies a block of 32-bit words from the memory-mapped flash window to RAM (or any other slave), typically used as the SOC boot loader that fills instruction RAM before releasing the CPU. It is the initiator for the same Avalon slave protocol the flash bus interface and RAM slaves respond to. It issues one word read, then one word write, per iteration, and tolerates slaves that stall with multi-cycle WaitRequest.

## Interface
- `ADDR_W`, 32: Avalon byte-address width.
- `COUNT_W`, 16: word-count width.
- `BOOT_SRC`, 0: source byte address used by the auto-start after reset.
- `BOOT_DST`, 0: destination byte address used by the auto-start.
- `BOOT_WORDS`, 0: word count used by the auto-start. A value of 0 disables auto-start.
- `TIMEOUT`, 4095: maximum number of stalled cycles allowed per transfer.

Ports:
- `i_Clk`  in  1  clock.
- `i_nReset`  in  1  asynchronous active-low reset.
- `i_Start`  in  1  one-cycle start pulse. Ignored while `o_Busy` is high.
- `i_SrcAddr`  in  ADDR_W  source byte address, sampled on start.
- `i_DstAddr`  in  ADDR_W  destination byte address, sampled on start.
- `i_WordCount`  in  COUNT_W  number of words to copy, sampled on start.
- `o_Busy`  out  1  high from the cycle after start until the copy finishes.
- `o_Done`  out  1  sticky flag for a successful completion. Cleared by the next start.
- `o_Error`  out  1  sticky flag for a timeout. Cleared by the next start.
- `o_AV_Addr`  out  ADDR_W  Avalon address.
- `o_AV_ByteEn`  out  4  Avalon byte enables. Always 4'hF.
- `o_AV_Read`  out  1  Avalon read strobe.
- `o_AV_Write`  out  1  Avalon write strobe.
- `o_AV_WriteData`  out  32  Avalon write data.
- `i_AV_ReadData`  in  32  Avalon read data.
- `i_AV_WaitRequest`  in  1  Avalon stall from the slave.

## Operation
- **Reset values:** `o_Busy`=0, `o_Done`=0, `o_Error`=0, `o_AV_Read`=0, `o_AV_Write`=0, `o_AV_Addr`=0, `o_AV_WriteData`=0. State is IDLE.
- **Auto-start:** when `BOOT_WORDS` ≠ 0, the first cycle after reset deasserts behaves as a start using the `BOOT_*` values.
- **States and transitions:**
  - IDLE → on start: latch source, destination and count, then go to RD. If the count is 0, set `o_Done` directly and stay in IDLE.
  - RD: `o_AV_Read`=1, `o_AV_Addr`=current source address.
    - On transfer completion: capture `i_AV_ReadData` into the data register, deassert Read, go to WR.
  - WR: `o_AV_Write`=1, `o_AV_Addr`=current destination address, `o_AV_WriteData`=captured word.
    - On completion: deassert Write, add 4 to source and destination, decrement the count.
    - If the count was 1, go to DONE; otherwise go to RD.
  - DONE: set `o_Done`, drop `o_Busy`, return to IDLE.
  - ERR: set `o_Error`, drop `o_Busy`, return to IDLE.
- **Transfer completion rule:** slaves register WaitRequest. A command therefore completes on the first cycle, counted from the command's second asserted cycle onward, in which `i_AV_WaitRequest`=0. Read data is valid in that same cycle. WaitRequest in the command's first cycle is always ignored.
- **Command stability:** Read and Write are never asserted together. Address and data stay constant while a command is asserted. Strobes drop for exactly one cycle between RD and WR, and between WR and the next RD.
- **Timeout:** a stall counter clears at the start of each command and increments every stalled cycle. When it reaches `TIMEOUT`, drop the command and go to ERR. `TIMEOUT`=0 disables the check.
- **Address arithmetic:** addresses are modulo 2^ADDR_W and wrap silently. The low 2 bits are passed through unmodified.
- **Reset mid-copy:** asserting `i_nReset` during a copy forces reset values immediately, including strobes dropping asynchronously. No partial-state recovery is attempted.

## Timing
- Per word with zero-stall slaves: RD takes 2 cycles, plus 1 gap cycle, WR takes 2 cycles, plus 1 gap cycle, giving 6 cycles per word.
- Each stall cycle beyond that adds 1 cycle.
- Start to first `o_AV_Read`: 1 cycle.
- Last write completion to `o_Done` high: 1 cycle.
- All outputs are registered. There are no combinational paths from `i_AV_*` to `o_AV_*`.

## Structure
- Put the state encoding and the `TIMEOUT`/width defaults in a shared `soc_bus_pkg` alongside the other Avalon constants.
- One sub-module is natural: `av_master_port`. It owns one strobe, the second-cycle-onward completion detect and the stall counter. It is instantiated once and driven for both reads and writes, and is reusable by future masters.

## Test plan
- **Basic copy:** source 0x0000_0000, destination 0x1000_0000, count 4, zero-stall slave model.
  - Four words are copied in order; writes land at 0x1000_0000, 04, 08 and 0C.
  - `o_Done` rises 24 cycles after start.
- **Stalling slave:** flash model holds WaitRequest for 9 cycles per read.
  - Data is captured only on the completion cycle; the count is correct.
  - Read, address and write data are stable throughout each stall.
- **Zero count:** start with count 0.
  - No Avalon strobes; `o_Done`=1 one cycle later.
- **Timeout:** `TIMEOUT`=16, slave holds WaitRequest high forever.
  - Read drops after 16 stall cycles; `o_Error`=1, `o_Done`=0, `o_Busy`=0.
  - A new start clears `o_Error`.
- **Auto-boot:** `BOOT_WORDS`=3 with a pulse on `i_nReset`.
  - The copy begins without `i_Start`.
  - Reasserting reset mid-copy drops all strobes immediately and clears the flags.
- **Start while busy and address wrap:**
  - A start pulse during a copy is ignored.
  - Source 0xFFFF_FFFC with count 2 reads 0xFFFF_FFFC and then 0x0000_0000.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared Avalon-MM constants and the copy-master state encoding.
package soc_bus_pkg;

    localparam int         AV_ADDR_W      = 32;
    localparam int         AV_DATA_W      = 32;
    localparam logic [3:0] AV_BYTE_EN_ALL = 4'hF;
    localparam int         AV_WORD_BYTES  = 4;
    localparam int         COPY_COUNT_W   = 16;
    localparam int         COPY_TIMEOUT   = 4095;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } copyState_t;

    // Stall counter width; at least one bit even when the timeout is disabled.
    function automatic int stallWidth(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/av_master_port.sv
// One Avalon command slot: a single read or write strobe, completion detect
// from the command's second cycle onward (slaves register WaitRequest), and
// a per-command stall counter with optional timeout.
module av_master_port
    import soc_bus_pkg::*;
#(
    parameter int TIMEOUT = COPY_TIMEOUT
)(
    input  logic i_Clk,
    input  logic i_nReset,
    input  logic i_Issue,
    input  logic i_IsWrite,
    input  logic i_AV_WaitRequest,
    output logic o_Read,
    output logic o_Write,
    output logic o_Complete,
    output logic o_Timeout
);

    localparam int                 STALL_W    = stallWidth(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    logic               firstCycle;
    logic [STALL_W-1:0] stallCnt;
    logic               active;
    logic               stalled;

    // WaitRequest seen in the first command cycle belongs to the previous
    // bus cycle, so it is ignored.
    assign active     = o_Read | o_Write;
    assign stalled    = active & ~firstCycle & i_AV_WaitRequest;
    assign o_Complete = active & ~firstCycle & ~i_AV_WaitRequest;
    // Fires on the stall that brings the count up to TIMEOUT.
    assign o_Timeout  = (TIMEOUT != 0) && stalled && (stallCnt == STALL_LAST);

    // Strobe, first-cycle marker and stall counter for the active command.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            o_Read     <= 1'b0;
            o_Write    <= 1'b0;
            firstCycle <= 1'b0;
            stallCnt   <= '0;
        end else if (i_Issue) begin
            o_Read     <= ~i_IsWrite;
            o_Write    <= i_IsWrite;
            firstCycle <= 1'b1;
            stallCnt   <= '0;
        end else if (o_Complete || o_Timeout) begin
            o_Read     <= 1'b0;
            o_Write    <= 1'b0;
            firstCycle <= 1'b0;
        end else if (active) begin
            firstCycle <= 1'b0;
            if (stalled) begin
                stallCnt <= stallCnt + STALL_W'(1);
            end
        end
    end

endmodule

// File: rtl/flash_copy_master.sv
// Avalon-MM block copier: read one word, write it, repeat. Used as the boot
// loader that fills instruction RAM from flash before the CPU is released.
// Handshake: a command holds Read or Write with stable address/data until
// the first cycle, from its second cycle on, where WaitRequest is low; read
// data is taken in that cycle and the strobe drops for one cycle after it.
module flash_copy_master
    import soc_bus_pkg::*;
#(
    parameter int                 ADDR_W     = AV_ADDR_W,
    parameter int                 COUNT_W    = COPY_COUNT_W,
    parameter logic [ADDR_W-1:0]  BOOT_SRC   = '0,
    parameter logic [ADDR_W-1:0]  BOOT_DST   = '0,
    parameter logic [COUNT_W-1:0] BOOT_WORDS = '0,
    parameter int                 TIMEOUT    = COPY_TIMEOUT
)(
    input  logic               i_Clk,
    input  logic               i_nReset,
    input  logic               i_Start,
    input  logic [ADDR_W-1:0]  i_SrcAddr,
    input  logic [ADDR_W-1:0]  i_DstAddr,
    input  logic [COUNT_W-1:0] i_WordCount,
    output logic               o_Busy,
    output logic               o_Done,
    output logic               o_Error,
    output logic [ADDR_W-1:0]  o_AV_Addr,
    output logic [3:0]         o_AV_ByteEn,
    output logic               o_AV_Read,
    output logic               o_AV_Write,
    output logic [31:0]        o_AV_WriteData,
    input  logic [31:0]        i_AV_ReadData,
    input  logic               i_AV_WaitRequest,
    output logic [2:0]         o_DbgState
);

    copyState_t         state, nextState;
    logic [ADDR_W-1:0]  srcAddr, dstAddr, issueAddr;
    logic [COUNT_W-1:0] wordsLeft;
    logic               bootPending;
    logic               startReq, issue, issueWrite, capture, advance;
    logic               portComplete, portTimeout;
    logic [ADDR_W-1:0]  startSrc, startDst;
    logic [COUNT_W-1:0] startCount;

    assign o_AV_ByteEn = AV_BYTE_EN_ALL;
    assign o_DbgState  = state;

    // The boot request stands in for i_Start during the first cycle out of reset.
    assign startSrc   = bootPending ? BOOT_SRC   : i_SrcAddr;
    assign startDst   = bootPending ? BOOT_DST   : i_DstAddr;
    assign startCount = bootPending ? BOOT_WORDS : i_WordCount;
    assign startReq   = (i_Start || bootPending) &&
                        (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

    av_master_port #(.TIMEOUT(TIMEOUT)) uPort (
        .i_Clk            (i_Clk),
        .i_nReset         (i_nReset),
        .i_Issue          (issue),
        .i_IsWrite        (issueWrite),
        .i_AV_WaitRequest (i_AV_WaitRequest),
        .o_Read           (o_AV_Read),
        .o_Write          (o_AV_Write),
        .o_Complete       (portComplete),
        .o_Timeout        (portTimeout)
    );

    // State register.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and command issue; an idle strobe inside RD/WR is the gap cycle.
    always_comb begin
        nextState  = state;
        issue      = 1'b0;
        issueWrite = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        issueAddr  = srcAddr;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                nextState = ST_IDLE;
                issueAddr = startSrc;
                if (startReq && startCount != '0) begin
                    nextState = ST_RD;
                    issue     = 1'b1;
                end
            end
            ST_RD: begin
                if (portTimeout) begin
                    nextState = ST_ERR;
                end else if (portComplete) begin
                    capture   = 1'b1;
                    nextState = ST_WR;
                end else if (!(o_AV_Read || o_AV_Write)) begin
                    issue = 1'b1;
                end
            end
            ST_WR: begin
                issueAddr = dstAddr;
                if (portTimeout) begin
                    nextState = ST_ERR;
                end else if (portComplete) begin
                    advance   = 1'b1;
                    nextState = (wordsLeft == COUNT_W'(1)) ? ST_DONE : ST_RD;
                end else if (!(o_AV_Read || o_AV_Write)) begin
                    issue      = 1'b1;
                    issueWrite = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Address/count bookkeeping, registered bus address/data and status flags.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            srcAddr        <= '0;
            dstAddr        <= '0;
            wordsLeft      <= '0;
            o_AV_Addr      <= '0;
            o_AV_WriteData <= '0;
            o_Busy         <= 1'b0;
            o_Done         <= 1'b0;
            o_Error        <= 1'b0;
            bootPending    <= (BOOT_WORDS != '0);
        end else begin
            bootPending <= 1'b0;
            if (issue) begin
                o_AV_Addr <= issueAddr;
            end
            if (capture) begin
                o_AV_WriteData <= i_AV_ReadData;
            end
            if (startReq) begin
                srcAddr   <= startSrc;
                dstAddr   <= startDst;
                wordsLeft <= startCount;
                o_Busy    <= (startCount != '0);
                o_Done    <= (startCount == '0);
                o_Error   <= 1'b0;
            end else if (advance) begin
                srcAddr   <= srcAddr + ADDR_W'(AV_WORD_BYTES);
                dstAddr   <= dstAddr + ADDR_W'(AV_WORD_BYTES);
                wordsLeft <= wordsLeft - COUNT_W'(1);
            end
            if (nextState == ST_DONE) begin
                o_Done <= 1'b1;
                o_Busy <= 1'b0;
            end else if (nextState == ST_ERR) begin
                o_Error <= 1'b1;
                o_Busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flash_copy_master.sv
// Bench for flash_copy_master: a stallable flash/RAM slave model, scoreboards
// of expected read addresses and write (address, data) pairs, and an
// auto-boot instance with its own reset.
module tb_flash_copy_master;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] srcIn = '0, dstIn = '0;
    logic [15:0] cntIn = '0;
    logic        busy, done, error, avRead, avWrite;
    logic [31:0] avAddr, avWData;
    logic [31:0] avRdData = '0;
    logic        avWait = 1'b0;
    logic [3:0]  avBe;
    logic [2:0]  dbgState;

    logic        bNReset = 1'b0;
    logic        bBusy, bDone, bError, bRead, bWrite;
    logic [31:0] bAddr, bWData, bRdData;
    logic [3:0]  bBe;
    logic [2:0]  bDbg;

    int          passCnt = 0;
    int          checkCnt = 0;
    int          stallHold = 0;
    int          rdCyc = 0, wrCyc = 0, bwCyc = 0;
    logic [31:0] rdHold;
    logic [63:0] wrHold;
    logic [31:0] expRdQ[$];
    logic [63:0] expQ[$];
    logic [63:0] expBootQ[$];

    localparam logic [31:0] BOOT_SRC = 32'h0000_0100;
    localparam logic [31:0] BOOT_DST = 32'h2000_0000;

    // Clock.
    always #5 clk = ~clk;

    flash_copy_master #(.TIMEOUT(16)) dut (
        .i_Clk(clk), .i_nReset(nReset), .i_Start(start),
        .i_SrcAddr(srcIn), .i_DstAddr(dstIn), .i_WordCount(cntIn),
        .o_Busy(busy), .o_Done(done), .o_Error(error),
        .o_AV_Addr(avAddr), .o_AV_ByteEn(avBe), .o_AV_Read(avRead),
        .o_AV_Write(avWrite), .o_AV_WriteData(avWData),
        .i_AV_ReadData(avRdData), .i_AV_WaitRequest(avWait),
        .o_DbgState(dbgState)
    );

    flash_copy_master #(.BOOT_SRC(BOOT_SRC), .BOOT_DST(BOOT_DST),
                        .BOOT_WORDS(16'd3)) dutBoot (
        .i_Clk(clk), .i_nReset(bNReset), .i_Start(1'b0),
        .i_SrcAddr(32'h0), .i_DstAddr(32'h0), .i_WordCount(16'h0),
        .o_Busy(bBusy), .o_Done(bDone), .o_Error(bError),
        .o_AV_Addr(bAddr), .o_AV_ByteEn(bBe), .o_AV_Read(bRead),
        .o_AV_Write(bWrite), .o_AV_WriteData(bWData),
        .i_AV_ReadData(bRdData), .i_AV_WaitRequest(1'b0),
        .o_DbgState(bDbg)
    );

    // Flash contents: a word derived from its own address.
    function automatic logic [31:0] srcWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bRdData = srcWord(bAddr);

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            passCnt++;
        end
    endtask

    // Slave model and monitor for the main instance, evaluated mid-cycle.
    always @(negedge clk) begin
        avWait = 1'b0;
        if (avRead && avWrite) checkVal("rd_wr_overlap", 1, 0);
        if (avRead) begin
            rdCyc++;
            avWait   = (rdCyc <= stallHold);
            avRdData = avWait ? (32'hBAD0_0000 | 32'(rdCyc)) : srcWord(avAddr);
            if (rdCyc == 1) rdHold = avAddr;
            else checkVal("rd_addr_stable", avAddr, rdHold);
            if (rdCyc >= 2 && !avWait) begin
                if (expRdQ.size() == 0) checkVal("rd_unexpected", 1, 0);
                else checkVal("rd_addr", avAddr, expRdQ.pop_front());
            end
        end else begin
            rdCyc = 0;
        end
        if (avWrite) begin
            wrCyc++;
            if (wrCyc == 1) wrHold = {avAddr, avWData};
            else checkVal("wr_stable", {avAddr, avWData}, wrHold);
            if (wrCyc == 2) begin
                if (expQ.size() == 0) checkVal("wr_unexpected", 1, 0);
                else checkVal("wr_addr_data", {avAddr, avWData}, expQ.pop_front());
            end
        end else begin
            wrCyc = 0;
        end
    end

    // Monitor for the auto-boot instance (zero-stall slave).
    always @(negedge clk) begin
        if (bWrite && bNReset) begin
            bwCyc++;
            if (bwCyc == 2) begin
                if (expBootQ.size() == 0) checkVal("boot_wr_unexpected", 1, 0);
                else checkVal("boot_wr", {bAddr, bWData}, expBootQ.pop_front());
            end
        end else begin
            bwCyc = 0;
        end
    end

    // Push expectations, then pulse start for one cycle; returns in the cycle after start.
    task automatic startCopy(input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] cnt, input bit expectIt);
        logic [31:0] a;
        if (expectIt) begin
            for (int i = 0; i < int'(cnt); i++) begin
                a = src + 32'(4 * i);
                expRdQ.push_back(a);
                expQ.push_back({dst + 32'(4 * i), srcWord(a)});
            end
        end
        @(negedge clk);
        start = 1'b1; srcIn = src; dstIn = dst; cntIn = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkVal("copy_finished", done || error, 1);
    endtask

    task automatic checkDrained(input string tag);
        checkVal({tag, "_rd_q"}, expRdQ.size(), 0);
        checkVal({tag, "_wr_q"}, expQ.size(), 0);
        expRdQ.delete();
        expQ.delete();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        int hi;
        logic [31:0] src;
        logic [15:0] cnt;

        // Reset values.
        repeat (3) @(negedge clk);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_error", error, 0);
        checkVal("rst_read", avRead, 0);
        checkVal("rst_write", avWrite, 0);
        checkVal("rst_addr", avAddr, 0);
        checkVal("rst_wdata", avWData, 0);
        checkVal("rst_state", dbgState, 3'd0);
        checkVal("byte_en", avBe, 4'hF);
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        checkVal("idle_no_autostart", busy, 0);

        // Basic copy, zero-stall slave.
        stallHold = 0;
        startCopy(32'h0000_0000, 32'h1000_0000, 16'd4, 1);
        checkVal("first_read", avRead, 1);
        checkVal("busy_after_start", busy, 1);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkVal("done_latency", cyc, 24);
        checkVal("basic_busy_low", busy, 0);
        checkDrained("basic");

        // Stalling flash with a start pulse while busy that must be ignored.
        stallHold = 9;
        src = {22'($urandom_range(0, 4095)), 10'h0};
        cnt = 16'($urandom_range(2, 4));
        startCopy(src, 32'h3000_0000, cnt, 1);
        repeat (5) @(negedge clk);
        checkVal("stall_busy", busy, 1);
        start = 1'b1; srcIn = 32'h5000; dstIn = 32'h6000; cntIn = 16'd7;
        @(negedge clk);
        start = 1'b0;
        waitIdle(int'(cnt) * 30 + 50);
        checkVal("stall_done", done, 1);
        checkVal("stall_error", error, 0);
        checkDrained("stall");

        // Timeout: read held off forever.
        stallHold = 1000000;
        startCopy(32'h0000_0040, 32'h0000_5000, 16'd1, 0);
        hi = 0;
        while (avRead && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        checkVal("timeout_read_cycles", hi, 17);
        checkVal("timeout_error", error, 1);
        checkVal("timeout_done", done, 0);
        checkVal("timeout_busy", busy, 0);
        stallHold = 0;

        // Zero count: also clears the sticky error.
        startCopy(32'h0000_0080, 32'h0000_0090, 16'd0, 1);
        checkVal("zero_done", done, 1);
        checkVal("zero_error_cleared", error, 0);
        checkVal("zero_busy", busy, 0);
        checkVal("zero_read", avRead, 0);
        checkVal("zero_write", avWrite, 0);
        repeat (3) @(negedge clk);
        checkVal("zero_no_strobe", avRead | avWrite, 0);

        // Address wrap.
        startCopy(32'hFFFF_FFFC, 32'hFFFF_FFF8, 16'd2, 1);
        checkVal("wrap_done_cleared", done, 0);
        waitIdle(60);
        checkVal("wrap_done", done, 1);
        checkDrained("wrap");

        // Auto-boot instance.
        for (int i = 0; i < 3; i++)
            expBootQ.push_back({BOOT_DST + 32'(4 * i), srcWord(BOOT_SRC + 32'(4 * i))});
        @(negedge clk);
        bNReset = 1'b1;
        @(negedge clk);
        checkVal("boot_first_read", bRead, 1);
        checkVal("boot_first_addr", bAddr, BOOT_SRC);
        checkVal("boot_busy", bBusy, 1);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 bNReset = 1'b0;
        #1;
        checkVal("boot_rst_read", bRead, 0);
        checkVal("boot_rst_write", bWrite, 0);
        checkVal("boot_rst_busy", bBusy, 0);
        checkVal("boot_rst_done", bDone, 0);
        checkVal("boot_rst_addr", bAddr, 0);
        expBootQ.delete();
        for (int i = 0; i < 3; i++)
            expBootQ.push_back({BOOT_DST + 32'(4 * i), srcWord(BOOT_SRC + 32'(4 * i))});
        @(negedge clk);
        bNReset = 1'b1;
        hi = 0;
        while (!bDone && hi < 60) begin
            @(negedge clk);
            hi++;
        end
        checkVal("boot_done", bDone, 1);
        checkVal("boot_error", bError, 0);
        checkVal("boot_drained", expBootQ.size(), 0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
